button_mode_sequencer: RTL and testbench

//  Parametrised successor of the 4-state button FSM. It converts debounced centre/left/right

---
 rtl/button_mode_sequencer_pkg.sv | 21 ++
 rtl/btn_repeat_gen.sv | 41 ++++
 rtl/button_mode_sequencer.sv | 124 ++++++++++++
 tb/tb_button_mode_sequencer.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/button_mode_sequencer_pkg.sv
// Shared state encoding and elaboration-time sizing helpers for the button mode sequencer.
package button_mode_sequencer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'b00,
        ST_ACTIVE    = 2'b01,
        ST_EXIT_WAIT = 2'b10
    } bms_state_e;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

    // Width that never collapses to zero bits for trivial ranges.
    function automatic int clog2_min1(input int v);
        return (v <= 1) ? 1 : $clog2(v);
    endfunction

endpackage

// File: rtl/btn_repeat_gen.sv
// Per-button rising-edge detect plus hold-to-repeat timer; fire is a one-cycle strobe.
module btn_repeat_gen #(
    parameter int CNT_W  = 4,
    parameter int DELAY  = 0,
    parameter int PERIOD = 1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn,
    input  logic clr,
    output logic fire
);
    // prev_low resets to 0 so a button held through reset never looks like a fresh press.
    logic             prev_low;
    logic [CNT_W-1:0] cnt;
    logic             edge_hit;
    logic             rep_hit;

    assign edge_hit = btn & prev_low & ~clr;
    assign rep_hit  = btn & ~clr & (cnt == CNT_W'(1));
    assign fire     = edge_hit | rep_hit;

    // cnt holds the cycles left until the next repeat; 0 means no repeat pending.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev_low <= 1'b0;
            cnt      <= '0;
        end else begin
            prev_low <= ~btn;
            if (clr || !btn || (DELAY == 0))
                cnt <= '0;
            else if (edge_hit)
                cnt <= CNT_W'(DELAY);
            else if (rep_hit)
                cnt <= CNT_W'(PERIOD);
            else if (cnt != '0)
                cnt <= cnt - 1'b1;
        end
    end

endmodule

// File: rtl/button_mode_sequencer.sv
// Converts debounced centre/left/right levels into a bounded mode index with
// edge stepping, optional auto-repeat, wrap/saturate ends and long-press exit.
module button_mode_sequencer
    import button_mode_sequencer_pkg::*;
#(
    parameter int NUM_MODES     = 4,
    parameter int INIT_IDX      = 0,
    parameter int WRAP          = 0,
    parameter int REPEAT_DELAY  = 0,
    parameter int REPEAT_PERIOD = 1,
    parameter int LONG_HOLD     = 0,
    localparam int IDX_W        = clog2_min1(NUM_MODES)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             btncZ,
    input  logic             btnlZ,
    input  logic             btnrZ,
    output logic             active,
    output logic [IDX_W-1:0] mode_idx,
    output logic             step_up,
    output logic             step_dn,
    output logic             at_lo,
    output logic             at_hi
);
    localparam int CNT_W = clog2_min1(max3(REPEAT_DELAY, REPEAT_PERIOD, LONG_HOLD) + 1);
    localparam logic [IDX_W:0]   MODES_X = (IDX_W+1)'(NUM_MODES);
    localparam logic [IDX_W-1:0] IDX_TOP = IDX_W'(NUM_MODES - 1);
    localparam logic [IDX_W-1:0] IDX_INI = IDX_W'(INIT_IDX);

    bms_state_e       state, state_nxt;
    logic [IDX_W-1:0] idx_q, idx_nxt;
    logic             up_nxt, dn_nxt;
    logic             c_prev_low;
    logic [CNT_W-1:0] hold_cnt;
    logic             c_rise, rpt_clr, fire_l, fire_r, long_exit;
    logic [IDX_W:0]   idx_inc;

    assign c_rise    = btncZ & c_prev_low;
    // Centre has priority and simultaneous L/R cancels both repeat sequences.
    assign rpt_clr   = (btnlZ & btnrZ) | btncZ | (state != ST_ACTIVE);
    assign long_exit = (LONG_HOLD > 0) && (state == ST_ACTIVE) && btncZ &&
                       (hold_cnt == CNT_W'(LONG_HOLD - 1));
    assign idx_inc   = {1'b0, idx_q} + 1'b1;

    btn_repeat_gen #(.CNT_W(CNT_W), .DELAY(REPEAT_DELAY), .PERIOD(REPEAT_PERIOD)) u_rpt_l (
        .clk(clk), .rst_n(rst_n), .btn(btnlZ), .clr(rpt_clr), .fire(fire_l)
    );
    btn_repeat_gen #(.CNT_W(CNT_W), .DELAY(REPEAT_DELAY), .PERIOD(REPEAT_PERIOD)) u_rpt_r (
        .clk(clk), .rst_n(rst_n), .btn(btnrZ), .clr(rpt_clr), .fire(fire_r)
    );

    always_comb begin
        state_nxt = state;
        idx_nxt   = idx_q;
        up_nxt    = 1'b0;
        dn_nxt    = 1'b0;
        case (state)
            ST_IDLE: begin
                if (c_rise) begin
                    state_nxt = ST_ACTIVE;
                    idx_nxt   = IDX_INI;
                end
            end
            ST_ACTIVE: begin
                if (c_rise) begin
                    idx_nxt = IDX_INI;
                end else if (fire_l) begin
                    if (idx_inc < MODES_X) begin
                        idx_nxt = idx_inc[IDX_W-1:0];
                        up_nxt  = 1'b1;
                    end else if (WRAP != 0) begin
                        idx_nxt = '0;
                        up_nxt  = 1'b1;
                    end
                end else if (fire_r) begin
                    if (idx_q != '0) begin
                        idx_nxt = idx_q - IDX_W'(1);
                        dn_nxt  = 1'b1;
                    end else if (WRAP != 0) begin
                        idx_nxt = IDX_TOP;
                        dn_nxt  = 1'b1;
                    end
                end
                if (long_exit)
                    state_nxt = ST_EXIT_WAIT;
            end
            ST_EXIT_WAIT: begin
                if (!btncZ)
                    state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            idx_q      <= '0;
            step_up    <= 1'b0;
            step_dn    <= 1'b0;
            c_prev_low <= 1'b0;
            hold_cnt   <= '0;
        end else begin
            state      <= state_nxt;
            idx_q      <= idx_nxt;
            step_up    <= up_nxt;
            step_dn    <= dn_nxt;
            c_prev_low <= ~btncZ;
            if ((state == ST_ACTIVE) && btncZ) begin
                if (hold_cnt != '1)
                    hold_cnt <= hold_cnt + 1'b1;
            end else begin
                hold_cnt <= '0;
            end
        end
    end

    assign active   = (state != ST_IDLE);
    assign mode_idx = idx_q;
    assign at_lo    = (idx_q == '0);
    assign at_hi    = (idx_q == IDX_TOP);

endmodule

// File: tb/tb_button_mode_sequencer.sv
// Directed bench: a saturating/repeating/long-hold instance and a wrapping instance share stimulus.
module tb_button_mode_sequencer;
    logic clk = 1'b0;
    logic rst_n;
    logic btncZ, btnlZ, btnrZ;

    logic       s_act, s_up, s_dn, s_lo, s_hi;
    logic [1:0] s_idx;
    logic       w_act, w_up, w_dn, w_lo, w_hi;
    logic [1:0] w_idx;

    int n_chk = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    button_mode_sequencer #(
        .NUM_MODES(4), .INIT_IDX(0), .WRAP(0),
        .REPEAT_DELAY(5), .REPEAT_PERIOD(2), .LONG_HOLD(8)
    ) dut_sat (
        .clk(clk), .rst_n(rst_n), .btncZ(btncZ), .btnlZ(btnlZ), .btnrZ(btnrZ),
        .active(s_act), .mode_idx(s_idx), .step_up(s_up), .step_dn(s_dn),
        .at_lo(s_lo), .at_hi(s_hi)
    );

    button_mode_sequencer #(
        .NUM_MODES(4), .INIT_IDX(0), .WRAP(1),
        .REPEAT_DELAY(0), .REPEAT_PERIOD(1), .LONG_HOLD(0)
    ) dut_wrp (
        .clk(clk), .rst_n(rst_n), .btncZ(btncZ), .btnlZ(btnlZ), .btnrZ(btnrZ),
        .active(w_act), .mode_idx(w_idx), .step_up(w_up), .step_dn(w_dn),
        .at_lo(w_lo), .at_hi(w_hi)
    );

    task automatic chk(input string tag, input int got, input int exp);
        n_chk++;
        if (got != exp) begin
            n_err++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic press(input bit l, input bit r);
        btnlZ = l;
        btnrZ = r;
        tick();
    endtask

    initial begin
        rst_n = 1'b0;
        btncZ = 1'b0;
        btnlZ = 1'b0;
        btnrZ = 1'b0;
        #12;
        chk("rst_active", s_act, 0);
        chk("rst_idx", s_idx, 0);
        chk("rst_up", s_up, 0);
        chk("rst_dn", s_dn, 0);
        chk("rst_lo", s_lo, 1);
        rst_n = 1'b1;
        tick();

        // 1: centre enters ACTIVE at INIT_IDX
        btncZ = 1'b1; tick();
        chk("t1_active", s_act, 1);
        chk("t1_idx", s_idx, 0);
        chk("t1_lo", s_lo, 1);
        chk("t1_up", s_up, 0);
        chk("t1_w_active", w_act, 1);
        btncZ = 1'b0; tick();

        // 2: three presses climb both instances to 3
        for (int i = 1; i <= 3; i++) begin
            press(1, 0);
            chk("t2_idx", s_idx, i);
            chk("t2_up", s_up, 1);
            chk("t2_w_idx", w_idx, i);
            press(0, 0);
            chk("t2_up_clr", s_up, 0);
        end
        chk("t2_hi", s_hi, 1);

        // 4th press: saturate drops it, wrap goes to 0
        press(1, 0);
        chk("t2_sat_idx", s_idx, 3);
        chk("t2_sat_up", s_up, 0);
        chk("t2_sat_hi", s_hi, 1);
        chk("t3_w_idx", w_idx, 0);
        chk("t3_w_up", w_up, 1);
        chk("t3_w_lo", w_lo, 1);
        press(0, 0);

        // 3: right press, wrap 0 -> 3, saturate 3 -> 2
        press(0, 1);
        chk("t3_w_idx_dn", w_idx, 3);
        chk("t3_w_dn", w_dn, 1);
        chk("t3_w_hi", w_hi, 1);
        chk("t3_sat_idx_dn", s_idx, 2);
        chk("t3_sat_dn", s_dn, 1);
        press(0, 0);

        // centre reload in ACTIVE, no pulse
        btncZ = 1'b1; tick();
        chk("reload_idx", s_idx, 0);
        chk("reload_up", s_up, 0);
        chk("reload_dn", s_dn, 0);
        chk("reload_w_idx", w_idx, 0);
        btncZ = 1'b0; tick();

        // 4: hold left 12 cycles; steps at 1,6,8 then capped
        btnlZ = 1'b1;
        for (int k = 1; k <= 12; k++) begin
            tick();
            chk($sformatf("t4_idx_c%0d", k), s_idx, (k >= 8) ? 3 : (k >= 6) ? 2 : 1);
            chk($sformatf("t4_up_c%0d", k), s_up, (k == 1 || k == 6 || k == 8) ? 1 : 0);
        end
        chk("t4_w_idx", w_idx, 1);
        press(0, 0);

        // 5: L and R together, then L released with R held: no step
        press(1, 1);
        chk("t5_both_up", s_up, 0);
        chk("t5_both_dn", s_dn, 0);
        btnlZ = 1'b0;
        for (int k = 0; k < 8; k++) begin
            tick();
            chk("t5_rheld_dn", s_dn, 0);
        end
        chk("t5_idx", s_idx, 3);
        chk("t5_w_idx", w_idx, 1);
        press(0, 0);

        // centre held while left rises: no step then or after centre release
        btncZ = 1'b1; tick();
        chk("t5_c_reload", s_idx, 0);
        btnlZ = 1'b1; tick();
        chk("t5_c_idx", s_idx, 0);
        chk("t5_c_up", s_up, 0);
        btncZ = 1'b0; tick();
        chk("t5_c_rel_idx", s_idx, 0);
        chk("t5_c_rel_up", s_up, 0);
        press(0, 0);

        // 6a: centre held 7 cycles stays ACTIVE
        btncZ = 1'b1;
        for (int k = 0; k < 7; k++) tick();
        btncZ = 1'b0; tick();
        chk("t6_7hold_active", s_act, 1);
        press(1, 0);
        chk("t6_7hold_step", s_idx, 1);
        press(0, 0);

        // 6b: 8 cycles -> EXIT_WAIT, release -> IDLE
        btncZ = 1'b1;
        for (int k = 0; k < 8; k++) tick();
        chk("t6_exitwait_active", s_act, 1);
        press(1, 0);
        chk("t6_exitwait_nostep", s_up, 0);
        btnlZ = 1'b0;
        btncZ = 1'b0; tick();
        chk("t6_idle_active", s_act, 0);
        chk("t6_idle_idx", s_idx, 0);
        press(1, 0);
        chk("t6_idle_ignore_l", s_idx, 0);
        chk("t6_idle_ignore_up", s_up, 0);
        press(0, 0);

        // reset asserted right as a step pulse is showing
        btncZ = 1'b1; tick();
        btncZ = 1'b0; tick();
        press(1, 0);
        chk("t6_pre_rst_idx", s_idx, 1);
        chk("t6_pre_rst_up", s_up, 1);
        rst_n = 1'b0;
        #1;
        chk("t6_rst_idx", s_idx, 0);
        chk("t6_rst_up", s_up, 0);
        chk("t6_rst_active", s_act, 0);
        chk("t6_rst_lo", s_lo, 1);
        #2 rst_n = 1'b1;
        tick();
        btncZ = 1'b1; tick();
        chk("t6_post_active", s_act, 1);
        btncZ = 1'b0;
        for (int k = 0; k < 7; k++) begin
            tick();
            chk("t6_post_up", s_up, 0);
        end
        chk("t6_post_idx", s_idx, 0);
        press(0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_err);
        $finish;
    end

endmodule
